// File: rtl/am_demod_pkg.sv
// Shared types, default parameters and helpers for the AM envelope demodulator.
package am_demod_pkg;

  typedef enum logic {
    ACQ = 1'b0,
    RUN = 1'b1
  } state_t;

  localparam int unsigned DEF_DW       = 16;
  localparam int unsigned DEF_LOG2_DEC = 4;
  localparam int unsigned DEF_ALPHA_SH = 4;
  localparam int unsigned DEF_THRESH   = 64;
  localparam int unsigned DEF_LOSS_N   = 8;

  // Signed a - b, clamped to the range of a w-bit two's complement value.
  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        w);
    logic signed [32:0] d;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    d  = 33'(a) - 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (d > hi) begin
      return 32'(hi);
    end else if (d < lo) begin
      return 32'(lo);
    end
    return 32'(d);
  endfunction

endpackage

// File: rtl/am_envelope_accum.sv
// Full-wave rectifier and boxcar accumulator producing one envelope value per block.
module am_envelope_accum
  import am_demod_pkg::*;
#(
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned LOG2_DEC = DEF_LOG2_DEC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic [DW-2:0] env,
  output logic          env_valid
);

  localparam int unsigned MW = DW - 1;
  localparam int unsigned AW = MW + LOG2_DEC;
  localparam logic [LOG2_DEC-1:0] CNT_LAST = '1;

  logic [MW-1:0]       mag;
  logic [DW-1:0]       neg;
  logic [AW-1:0]       acc;
  logic [LOG2_DEC-1:0] cnt;
  logic                block_done;

  // Absolute value; the most negative code saturates to the largest magnitude.
  always_comb begin
    neg = -in_data;
    mag = in_data[MW-1:0];
    if (in_data[DW-1]) begin
      if (in_data[MW-1:0] == '0) begin
        mag = '1;
      end else begin
        mag = neg[MW-1:0];
      end
    end
  end

  // Sum magnitudes over a block; the finished sum is scaled into env one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      block_done <= 1'b0;
      env        <= '0;
      env_valid  <= 1'b0;
    end else begin
      env_valid  <= block_done;
      block_done <= 1'b0;
      if (block_done) begin
        env <= MW'(acc >> LOG2_DEC);
      end
      if (in_valid) begin
        if (block_done) begin
          acc <= AW'(mag);
        end else begin
          acc <= acc + AW'(mag);
        end
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          block_done <= 1'b1;
        end
      end else if (block_done) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: rtl/am_demod.sv
// AM envelope demodulator: envelope, DC removal, carrier detect and one-entry output buffer.
module am_demod
  import am_demod_pkg::*;
#(
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned LOG2_DEC = DEF_LOG2_DEC,
  parameter int unsigned ALPHA_SH = DEF_ALPHA_SH,
  parameter int unsigned THRESH   = DEF_THRESH,
  parameter int unsigned LOSS_N   = DEF_LOSS_N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          carrier_ok,
  output logic          overflow
);

  localparam int unsigned MW  = DW - 1;
  localparam int unsigned DCW = MW + ALPHA_SH;
  localparam int unsigned LCW = $clog2(LOSS_N + 1);
  localparam logic [MW-1:0]       THR       = MW'(THRESH);
  localparam logic [LCW-1:0]      LOSS_LAST = LCW'(LOSS_N - 1);
  localparam logic [ALPHA_SH-1:0] BLK_LAST  = '1;

  logic [MW-1:0]       env;
  logic                env_valid;
  state_t              state;
  logic [DCW-1:0]      dc;
  logic [MW-1:0]       dc_int;
  logic [DCW-1:0]      dc_trk;
  logic [DW-1:0]       msg;
  logic                env_hit;
  logic                emit;
  logic [ALPHA_SH-1:0] blk_cnt;
  logic [LCW-1:0]      loss_cnt;
  logic                seed_pend;

  am_envelope_accum #(
    .DW       (DW),
    .LOG2_DEC (LOG2_DEC)
  ) u_accum (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .env       (env),
    .env_valid (env_valid)
  );

  // Tracker arithmetic and the decision whether this block yields an output.
  always_comb begin
    dc_int  = MW'(dc >> ALPHA_SH);
    dc_trk  = dc + DCW'(env) - DCW'(dc_int);
    msg     = DW'(sat_sub(32'($signed({1'b0, env})), 32'($signed({1'b0, dc_int})), DW));
    env_hit = (env >= THR);
    emit    = env_valid && (state == RUN) && !(!env_hit && (loss_cnt == LOSS_LAST));
  end

  // Acquisition/run state machine with the DC tracker, advanced once per block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ACQ;
      carrier_ok <= 1'b0;
      dc         <= '0;
      blk_cnt    <= '0;
      loss_cnt   <= '0;
      seed_pend  <= 1'b1;
    end else if (env_valid) begin
      case (state)
        ACQ: begin
          dc        <= seed_pend ? (DCW'(env) << ALPHA_SH) : dc_trk;
          seed_pend <= 1'b0;
          if (blk_cnt == BLK_LAST) begin
            blk_cnt <= '0;
            if (env_hit) begin
              state      <= RUN;
              carrier_ok <= 1'b1;
              loss_cnt   <= '0;
            end
          end else begin
            blk_cnt <= blk_cnt + 1'b1;
          end
        end
        RUN: begin
          dc <= dc_trk;
          if (env_hit) begin
            loss_cnt <= '0;
          end else if (loss_cnt == LOSS_LAST) begin
            state      <= ACQ;
            carrier_ok <= 1'b0;
            seed_pend  <= 1'b1;
            blk_cnt    <= '0;
            loss_cnt   <= '0;
          end else begin
            loss_cnt <= loss_cnt + 1'b1;
          end
        end
        default: begin
          state      <= ACQ;
          carrier_ok <= 1'b0;
        end
      endcase
    end
  end

  // One-entry output buffer; a result arriving while it is stuck full is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else if (emit) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_data  <= msg;
      end else begin
        overflow <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_am_demod.sv
// Directed testbench for am_demod with hand-computed expectations.
module tb_am_demod;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          carrier_ok;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int outq[$];
  int vcyc = 0;

  am_demod dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .carrier_ok (carrier_ok),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted outputs and count cycles with out_valid high.
  always @(negedge clk) begin
    if (out_valid && out_ready) outq.push_back(int'($signed(out_data)));
    if (out_valid) vcyc <= vcyc + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic feed(input int amp, input bit alt, input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      in_valid = 1'b1;
      in_data  = DW'((alt && i[0]) ? -amp : amp);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_carrier_ok", int'(carrier_ok), 0);
    check("rst_overflow", int'(overflow), 0);

    // Constant 1000: acquire after 16 blocks, then zero outputs once per block
    feed(1000, 1'b0, 16 * 16);
    idle(3);
    check("const_carrier_ok", int'(carrier_ok), 1);
    check("const_no_acq_out", outq.size(), 0);
    vcyc = 0;
    feed(1000, 1'b0, 4 * 16);
    idle(3);
    check("const_out_count", outq.size(), 4);
    check("const_valid_cycles", vcyc, 4);
    for (int i = 0; i < outq.size(); i++) check("const_out_zero", outq[i], 0);

    // Alternating carrier with amplitude step in RUN
    do_reset();
    outq.delete();
    feed(1000, 1'b1, 18 * 16);
    idle(3);
    check("step_pre_count", outq.size(), 2);
    outq.delete();
    feed(1200, 1'b1, 3 * 16);
    idle(3);
    check("step_count", outq.size(), 3);
    if (outq.size() == 3) begin
      check("step_out0", outq[0], 200);
      check("step_out1", outq[1], 188);
      check("step_out2", outq[2], 176);
    end

    // Most negative input saturates without wrap
    do_reset();
    outq.delete();
    feed(-32768, 1'b0, 17 * 16);
    idle(3);
    check("minneg_env", int'(dut.env), 32767);
    check("minneg_count", outq.size(), 1);
    if (outq.size() == 1) check("minneg_out", outq[0], 0);

    // Backpressure across two RUN results
    do_reset();
    outq.delete();
    feed(1000, 1'b1, 16 * 16);
    idle(3);
    out_ready = 1'b0;
    feed(1200, 1'b1, 16);
    idle(3);
    check("bp_valid", int'(out_valid), 1);
    check("bp_data_first", int'($signed(out_data)), 200);
    feed(1200, 1'b1, 16);
    idle(3);
    check("bp_data_held", int'($signed(out_data)), 200);
    check("bp_overflow", int'(overflow), 1);
    out_ready = 1'b1;
    idle(2);
    check("bp_drain_count", outq.size(), 1);
    if (outq.size() == 1) check("bp_drain_val", outq[0], 200);
    check("bp_valid_after", int'(out_valid), 0);
    check("bp_overflow_sticky", int'(overflow), 1);

    // Carrier loss after 8 silent blocks, then reacquisition
    do_reset();
    outq.delete();
    feed(1000, 1'b1, 17 * 16);
    idle(3);
    outq.delete();
    feed(0, 1'b0, 7 * 16);
    idle(3);
    check("loss_still_ok", int'(carrier_ok), 1);
    check("loss_count7", outq.size(), 7);
    if (outq.size() >= 2) begin
      check("loss_out0", outq[0], -1000);
      check("loss_out1", outq[1], -937);
    end
    feed(0, 1'b0, 16);
    idle(3);
    check("loss_dropped", int'(carrier_ok), 0);
    check("loss_no_out", outq.size(), 7);
    feed(1000, 1'b1, 15 * 16);
    idle(3);
    check("reacq_not_yet", int'(carrier_ok), 0);
    feed(1000, 1'b1, 16);
    idle(3);
    check("reacq_ok", int'(carrier_ok), 1);

    // Reset mid-block discards partial sum and buffered output
    do_reset();
    feed(1000, 1'b1, 16 * 16);
    idle(3);
    out_ready = 1'b0;
    feed(1200, 1'b1, 16);
    idle(3);
    check("mid_buffered", int'(out_valid), 1);
    feed(30000, 1'b0, 7);
    do_reset();
    check("mid_out_valid", int'(out_valid), 0);
    check("mid_out_data", int'(out_data), 0);
    check("mid_carrier_ok", int'(carrier_ok), 0);
    check("mid_overflow", int'(overflow), 0);
    out_ready = 1'b1;
    feed(1000, 1'b1, 16);
    idle(3);
    check("mid_env_post", int'(dut.env), 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
